// File: rtl/reg_share_arbiter_if.sv
// Bus between the four client datapaths and the shared-register arbiter.
// Clients drive request/lock/write fields; the arbiter returns grant, owner,
// busy and the shared register contents.
interface reg_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [3:0]         wr;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic [1:0]         owner;
    logic               busy;
    logic [WIDTH-1:0]   q;

    modport master (output req, lock, wr, wdata, input gnt, owner, busy, q);
    modport slave  (input req, lock, wr, wdata, output gnt, owner, busy, q);
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register among four requesters.
// The grant is registered and one-hot. A locked owner keeps the register
// until it drops req or lock, or until it has held it MAXHOLD cycles while
// someone else is waiting. Only the granted requester's write lands in q.
module reg_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MAXHOLD = 16
) (
    input logic                  clk,
    input logic                  reset,
    reg_share_arbiter_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;
    localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);

    logic [0:0]       state;
    logic [3:0]       gnt;
    logic [1:0]       owner;
    logic [1:0]       ptr;
    logic [7:0]       hold_cnt;
    logic [WIDTH-1:0] q;

    logic             others_waiting;
    logic             release_own;
    logic             arbitrate;
    logic             found;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             wr_hit;

    // Release decision for the current owner and whether to arbitrate now.
    always_comb begin
        others_waiting = |(bus.req & ~gnt);
        release_own    = (state == OWN) &&
                         (!bus.req[owner] || !bus.lock[owner] ||
                          (hold_cnt == HOLD_MAX && others_waiting));
        arbitrate      = (state == IDLE) || release_own;
    end

    // Round-robin search from ptr. While owning, ptr is already owner+1, so
    // the released owner naturally ends up at lowest priority. Scanning in
    // descending distance lets the nearest requester overwrite the result.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant state: new grant on arbitration, otherwise extend and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (arbitrate) begin
            if (found) begin
                state    <= OWN;
                gnt      <= 4'b0001 << winner;
                owner    <= winner;
                ptr      <= winner + 2'd1;
                hold_cnt <= 8'd1;
            end else begin
                // owner and ptr keep the last owner's history in IDLE
                state    <= IDLE;
                gnt      <= '0;
                hold_cnt <= '0;
            end
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // gnt is one-hot on owner, so a hit always selects the owner's slice.
    assign wr_hit = |(gnt & bus.wr);

    // Shared register: loads only from the current grant holder.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (wr_hit) begin
            q <= bus.wdata[owner*WIDTH +: WIDTH];
        end
    end

    assign bus.gnt   = gnt;
    assign bus.owner = owner;
    assign bus.busy  = |gnt;
    assign bus.q     = q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed vector table, hold-limit sequences,
// then random traffic against a behavioural model of the sharing rules.
module tb_reg_share_arbiter;
    localparam int WIDTH   = 32;
    localparam int MAXHOLD = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    reg_share_arbiter #(.WIDTH(WIDTH), .MAXHOLD(MAXHOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: who owns, for how long, who is next in line
    int          m_cur;    // -1 when nobody holds the register
    int          m_last;   // reported owner index
    int          m_next;   // first requester to consider
    int          m_held;
    logic [31:0] m_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] rq;
        int win;
        bit rel;
        rq = bus.req;
        if (reset) begin
            m_cur = -1; m_last = 0; m_next = 0; m_held = 0; m_q = '0;
            return;
        end
        if (m_cur >= 0 && bus.wr[m_cur])
            m_q = bus.wdata[m_cur*WIDTH +: WIDTH];
        rel = (m_cur < 0) || !rq[m_cur] || !bus.lock[m_cur] ||
              (m_held >= MAXHOLD && (rq & ~(4'b1 << m_cur)) != 4'b0);
        if (!rel) begin
            if (m_held < MAXHOLD) m_held++;
            return;
        end
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && rq[(m_next + k) % 4]) win = (m_next + k) % 4;
        if (win >= 0) begin
            m_cur = win; m_last = win; m_next = (win + 1) % 4; m_held = 1;
        end else begin
            m_cur = -1;
        end
    endtask

    // one clock: advance model, take the edge, settle past it
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                         input logic [3:0] w, input logic [127:0] d);
        reset = r; bus.req = rq; bus.lock = lk; bus.wr = w; bus.wdata = d;
    endtask

    typedef struct {
        logic         rst;
        logic [3:0]   req;
        logic [3:0]   lock;
        logic [3:0]   wr;
        logic [127:0] wdata;
        logic [3:0]   e_gnt;
        logic [1:0]   e_owner;
        logic [31:0]  e_q;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [3:0] w, input logic [127:0] d,
                                input logic [3:0] g, input logic [1:0] o, input logic [31:0] eq);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.wr = w; v.wdata = d;
        v.e_gnt = g; v.e_owner = o; v.e_q = eq;
        return v;
    endfunction

    initial begin
        int cnt;
        int bad;
        logic [127:0] d;
        logic [3:0] rq, lk;

        drive(1'b1, 4'h0, 4'h0, 4'h0, '0);

        //           rst  req    lock   wr     wdata                                       gnt    own   q
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, '0,                                         4'h0, 2'd0, 32'h0));
        // single unlocked grant with a write
        vt.push_back(mk(0, 4'h1, 4'h0, 4'h1, {96'h0, 32'hDEADBEEF},                      4'h1, 2'd0, 32'h0));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h1, {96'h0, 32'hDEADBEEF},                      4'h0, 2'd0, 32'hDEADBEEF));
        // fairness from a fresh reset
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, '0,                                         4'h0, 2'd0, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h1, 2'd0, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h2, 2'd1, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h4, 2'd2, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h8, 2'd3, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h1, 2'd0, 32'h0));
        // wrap-around from owner 3
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h2, 2'd1, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h4, 2'd2, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h8, 2'd3, 32'h0));
        vt.push_back(mk(0, 4'h3, 4'h0, 4'h0, '0,                                         4'h1, 2'd0, 32'h0));
        vt.push_back(mk(0, 4'h3, 4'h0, 4'h0, '0,                                         4'h2, 2'd1, 32'h0));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, '0,                                         4'h0, 2'd1, 32'h0));
        // write isolation: requester 3 strobes while 1 owns
        vt.push_back(mk(0, 4'h2, 4'h2, 4'h0, '0,                                         4'h2, 2'd1, 32'h0));
        vt.push_back(mk(0, 4'h2, 4'h2, 4'h8, {32'h12345678, 96'h0},                      4'h2, 2'd1, 32'h0));
        vt.push_back(mk(0, 4'h2, 4'h2, 4'hA, {32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0}, 4'h2, 2'd1, 32'hCAFEF00D));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, '0,                                         4'h0, 2'd1, 32'hCAFEF00D));
        // reset in the middle of a locked burst drops the pending write
        vt.push_back(mk(0, 4'h1, 4'h1, 4'h0, '0,                                         4'h1, 2'd0, 32'hCAFEF00D));
        vt.push_back(mk(0, 4'h1, 4'h1, 4'h1, {96'h0, 32'h0000FFFF},                      4'h1, 2'd0, 32'h0000FFFF));
        vt.push_back(mk(1, 4'h1, 4'h1, 4'h1, {96'h0, 32'h11111111},                      4'h0, 2'd0, 32'h0));
        vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, '0,                                         4'h1, 2'd0, 32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].lock, vt[i].wr, vt[i].wdata);
            cyc();
            chk($sformatf("vec%0d_gnt", i),   32'(bus.gnt),   32'(vt[i].e_gnt));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(|vt[i].e_gnt));
            chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(vt[i].e_owner));
            chk($sformatf("vec%0d_q", i),     bus.q,          vt[i].e_q);
        end

        // hold limit: locked owner 0, requester 2 arrives in grant cycle 2
        drive(1'b1, 4'h0, 4'h0, 4'h0, '0); cyc();
        drive(1'b0, 4'h1, 4'h1, 4'h0, '0); cyc();
        chk("hold_first_gnt", 32'(bus.gnt), 32'h1);
        cyc();
        cnt = (bus.gnt == 4'h1) ? 2 : 0;
        bus.req = 4'h5;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.gnt != 4'h1) break;
            cnt++;
        end
        chk("hold_len", 32'(cnt), 32'(MAXHOLD));
        chk("hold_handover", 32'(bus.gnt), 32'h4);

        // no contender: lock holds indefinitely
        drive(1'b1, 4'h0, 4'h0, 4'h0, '0); cyc();
        drive(1'b0, 4'h1, 4'h1, 4'h0, '0);
        bad = 0;
        for (int i = 0; i < 3 * MAXHOLD; i++) begin
            cyc();
            if (bus.gnt != 4'h1) bad++;
        end
        chk("lock_no_contender", 32'(bad), 32'h0);

        // random traffic against the model
        drive(1'b1, 4'h0, 4'h0, 4'h0, '0); cyc();
        rq = 4'h0; lk = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
                if ($urandom_range(0, 7) == 0) lk[b] = ~lk[b];
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 99) == 0), rq, lk, 4'($urandom), d);
            cyc();
            chk("rnd_gnt",   32'(bus.gnt),   (m_cur < 0) ? 32'h0 : (32'h1 << m_cur));
            chk("rnd_busy",  32'(bus.busy),  32'(m_cur >= 0));
            chk("rnd_owner", 32'(bus.owner), 32'(m_last));
            chk("rnd_q",     bus.q,          m_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin controller that shares one WIDTH-bit storage register among four requesters. Each requester raises a request, receives a registered one-hot grant, and may write the register while it holds the grant. A per-requester lock extends ownership for bursts, and a hold limit bounds how long a locked owner can block others. The block sits between client datapaths and the shared register, which is instantiated inside it.

## Interface
- WIDTH, 32, data width of the shared register
- MAXHOLD, 16, maximum consecutive grant cycles for a locked owner while others are waiting; legal range 2..255

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  request, one bit per requester; level-sensitive
- lock  input  4  hold ownership past one cycle while set together with req
- wr  input  4  write strobe; honoured only for the current owner while granted
- wdata  input  4*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  4  registered one-hot grant; all zero when idle
- owner  output  2  index of the current or most recent owner
- busy  output  1  high whenever any gnt bit is high
- q  output  WIDTH  shared register contents

## Operation
- States:
  - IDLE: gnt=0.
  - OWN: exactly one gnt bit is high, equal to owner.
- Arbitration is round-robin. The search starts at ptr and wraps modulo 4. The first i with req[i]=1 wins.
- ptr is (last owner + 1) mod 4. Reset sets ptr=0, so requester 0 has first priority.
- IDLE → OWN: any req bit high at a clock edge. gnt and owner update at that edge; ptr moves to winner + 1.
- In OWN, the owner is released at the end of the cycle if any of these holds:
  - req[owner]=0;
  - lock[owner]=0;
  - hold_cnt==MAXHOLD and some other req bit is high.
- Without a release, the state stays OWN with the same owner and hold_cnt increments. hold_cnt saturates at MAXHOLD.
- On release, arbitration runs in the same cycle, searching from owner+1. The released owner's own req is eligible, but at lowest priority.
  - If a winner exists: back-to-back OWN→OWN with the new gnt on the next edge. There is no idle bubble.
  - If no req is set: next state is IDLE.
- An unlocked requester therefore gets exactly one grant cycle per win.
- hold_cnt is 1 in the first grant cycle and reloads to 1 on every new grant.
- Write: in any cycle with gnt[i]=1 and wr[i]=1, q loads wdata slice i at the next edge.
  - wr from non-owners is ignored.
  - wr in IDLE is ignored.
- q holds its value at all other times.
- owner keeps the last owner's index in IDLE.
- Reset at any edge, including mid-burst:
  - next state gnt=0, busy=0, owner=0, ptr=0, hold_cnt=0, q=0;
  - any write strobed in that cycle is dropped.

## Timing
- Grant latency: req rising in IDLE at cycle t gives gnt at t+1.
- Write latency: gnt&wr at cycle t gives the new q visible at t+1.
- Handover: the release decision in cycle t gives the new owner's gnt at t+1. Consecutive unlocked requesters receive grants on consecutive cycles.
- Worst-case wait for a requester with others locking: 3×MAXHOLD cycles, plus 1 for the initial grant latency.
- busy equals |gnt. Both are registered; no output depends combinationally on inputs.
- Requesters must hold req until they see gnt. Dropping req before the grant is legal and simply forfeits the slot.

## Test plan
- Reset, then req=4'b0001 with wr[0]=1 and wdata0=32'hDEADBEEF:
  - gnt=0001 one cycle after req;
  - q=DEADBEEF the cycle after that;
  - with lock=0, gnt returns to 0 after one grant cycle.
- Round-robin fairness, all four req held, lock=0:
  - gnt sequence is 0001, 0010, 0100, 1000, 0001 on consecutive cycles;
  - busy stays high.
- Lock and hold limit, MAXHOLD=16:
  - req0 with lock0 held, req2 raised at the second grant cycle;
  - gnt=0001 for exactly 16 cycles, then 0100;
  - with req2 absent, gnt=0001 persists indefinitely.
- Write isolation:
  - requester 1 owns; requester 3 pulses wr[3] with wdata3=32'h12345678;
  - q is unchanged, and only wr[1] data lands.
- Reset mid-burst:
  - assert reset during a locked burst that has written q=32'h0000FFFF;
  - next cycle gnt=0, busy=0, q=0;
  - with all req held after reset, the first grant goes to requester 0.
- Wrap-around:
  - last owner is 3, then req=4'b0011;
  - next grant is requester 0, then requester 1.
